// File: rtl/dac_sample_feeder.sv
// ---------------------------------------------------------------------------
// dac_sample_feeder
//
// Purpose:
//   Drives the two AD9781 data buses. Both buses sit at MIDSCALE until the SPI
//   configuration sequencer reports config_done and enable is high. After a
//   settling delay the block primes a small FIFO and then streams one DAC1/DAC2
//   sample pair per clk. Underruns are flagged (sticky), counted (saturating),
//   and recovered from by re-priming.
//
// Optional feature (macro DAC_TEST_PATTERN_EN):
//   Adds input test_mode. In S_RUN with test_mode=1 the FIFO is left alone.
//   dac1 carries a free-running ramp and dac2 carries its bitwise inverse.
//   Without the macro the port and the ramp logic are absent.
//
// Ports:
//   clk, rst             single clock, synchronous active-high reset
//   config_done, enable  level inputs; either low aborts to S_WAIT and flushes
//   s_valid/s_ready      upstream pair handshake
//   s_data1/s_data2      upstream DAC1/DAC2 samples
//   dac1_data/dac2_data  registered DAC buses
//   dac_valid            dac*_data carry FIFO data (or ramp), not midscale fill
//   streaming            high in S_RUN
//   underflow            sticky underrun flag
//   underflow_cnt        underrun event count, saturates at 255
//   fifo_level           FIFO occupancy 0..FIFO_DEPTH
//   state_dbg            current FSM state (0 WAIT, 1 SETTLE, 2 PRIME, 3 RUN)
//
// Handshake: a pair transfers on a posedge where s_valid && s_ready are both
// high. s_ready depends only on registered state, never on s_valid. The source
// may hold s_valid and the data until the transfer happens.
// ---------------------------------------------------------------------------
module dac_sample_feeder #(
  parameter int                DATA_W      = 14,
  parameter int                FIFO_DEPTH  = 16,
  parameter int                PRIME_LEVEL = 8,
  parameter int                START_DELAY = 64,
  parameter logic [DATA_W-1:0] MIDSCALE    = 14'h2000,
  localparam int               LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              config_done,
  input  logic              enable,
`ifdef DAC_TEST_PATTERN_EN
  input  logic              test_mode,
`endif
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data1,
  input  logic [DATA_W-1:0] s_data2,
  output logic [DATA_W-1:0] dac1_data,
  output logic [DATA_W-1:0] dac2_data,
  output logic              dac_valid,
  output logic              streaming,
  output logic              underflow,
  output logic [7:0]        underflow_cnt,
  output logic [LVL_W-1:0]  fifo_level,
  output logic [1:0]        state_dbg
);

  localparam int AW          = $clog2(FIFO_DEPTH);
  localparam int CNT_W       = (START_DELAY > 2) ? $clog2(START_DELAY) : 1;
  // START_DELAY of 0 or 1 both spend exactly one cycle in S_SETTLE.
  localparam int SETTLE_LAST = (START_DELAY > 0) ? START_DELAY - 1 : 0;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_SETTLE = 2'd1,
    S_PRIME  = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    settle_cnt_q, settle_cnt_d;
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   dac1_q, dac1_d;
  logic [DATA_W-1:0]   dac2_q, dac2_d;
  logic                dac_valid_q, dac_valid_d;
  logic                underflow_q, underflow_d;
  logic [7:0]          underflow_cnt_q, underflow_cnt_d;
`ifdef DAC_TEST_PATTERN_EN
  logic [DATA_W-1:0]   ramp_q, ramp_d;
`endif

  logic [DATA_W-1:0]   mem1_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   mem2_q [FIFO_DEPTH];

  logic [LVL_W-1:0]    level;
  logic                fifo_empty;
  logic                push;
  logic                go;
  logic                settle_done;

  assign level       = wr_ptr_q - rd_ptr_q;
  assign fifo_empty  = (level == '0);
  assign s_ready     = (state_q != S_WAIT) && (level < LVL_W'(FIFO_DEPTH));
  assign push        = s_valid && s_ready;
  assign go          = enable && config_done;
  assign settle_done = (settle_cnt_q == CNT_W'(SETTLE_LAST));

  always_comb begin
    state_d         = state_q;
    settle_cnt_d    = settle_cnt_q;
    wr_ptr_d        = wr_ptr_q + (AW + 1)'(push);
    rd_ptr_d        = rd_ptr_q;
    dac1_d          = dac1_q;
    dac2_d          = dac2_q;
    dac_valid_d     = dac_valid_q;
    underflow_d     = underflow_q;
    underflow_cnt_d = underflow_cnt_q;
`ifdef DAC_TEST_PATTERN_EN
    ramp_d          = ramp_q;
`endif

    case (state_q)
      S_WAIT: begin
        dac1_d      = MIDSCALE;
        dac2_d      = MIDSCALE;
        dac_valid_d = 1'b0;
        if (go) begin
          state_d      = S_SETTLE;
          settle_cnt_d = '0;
        end
      end

      S_SETTLE: begin
        dac1_d       = MIDSCALE;
        dac2_d       = MIDSCALE;
        dac_valid_d  = 1'b0;
        settle_cnt_d = settle_cnt_q + CNT_W'(1);
        if (settle_done) begin
          state_d = S_PRIME;
        end
      end

      S_PRIME: begin
        dac1_d      = MIDSCALE;
        dac2_d      = MIDSCALE;
        dac_valid_d = 1'b0;
        if (level >= LVL_W'(PRIME_LEVEL)) begin
          state_d = S_RUN;
`ifdef DAC_TEST_PATTERN_EN
          ramp_d  = '0;
`endif
        end
      end

      S_RUN: begin
`ifdef DAC_TEST_PATTERN_EN
        if (test_mode) begin
          // Ramp replaces FIFO data; the FIFO is neither popped nor checked.
          dac1_d      = ramp_q;
          dac2_d      = ~ramp_q;
          dac_valid_d = 1'b1;
          ramp_d      = ramp_q + DATA_W'(1);
        end else
`endif
        if (fifo_empty) begin
          // No bypass: a word pushed this same cycle is stored, not output.
          dac1_d      = MIDSCALE;
          dac2_d      = MIDSCALE;
          dac_valid_d = 1'b0;
          underflow_d = 1'b1;
          if (underflow_cnt_q != 8'hFF) begin
            underflow_cnt_d = underflow_cnt_q + 8'd1;
          end
          state_d = S_PRIME;
        end else begin
          dac1_d      = mem1_q[rd_ptr_q[AW-1:0]];
          dac2_d      = mem2_q[rd_ptr_q[AW-1:0]];
          dac_valid_d = 1'b1;
          rd_ptr_d    = rd_ptr_q + (AW + 1)'(1);
        end
      end

      default: begin
        state_d = S_WAIT;
      end
    endcase

    // Abort wins over everything: flush, midscale, and no underrun is booked
    // for a pop that the abort cancelled.
    if (!go) begin
      state_d         = S_WAIT;
      wr_ptr_d        = '0;
      rd_ptr_d        = '0;
      dac1_d          = MIDSCALE;
      dac2_d          = MIDSCALE;
      dac_valid_d     = 1'b0;
      underflow_d     = underflow_q;
      underflow_cnt_d = underflow_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_WAIT;
      settle_cnt_q    <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      dac1_q          <= MIDSCALE;
      dac2_q          <= MIDSCALE;
      dac_valid_q     <= 1'b0;
      underflow_q     <= 1'b0;
      underflow_cnt_q <= 8'd0;
    end else begin
      state_q         <= state_d;
      settle_cnt_q    <= settle_cnt_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      dac1_q          <= dac1_d;
      dac2_q          <= dac2_d;
      dac_valid_q     <= dac_valid_d;
      underflow_q     <= underflow_d;
      underflow_cnt_q <= underflow_cnt_d;
    end
  end

`ifdef DAC_TEST_PATTERN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ramp_q <= '0;
    end else begin
      ramp_q <= ramp_d;
    end
  end
`endif

  // Storage needs no reset: occupancy is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem1_q[wr_ptr_q[AW-1:0]] <= s_data1;
      mem2_q[wr_ptr_q[AW-1:0]] <= s_data2;
    end
  end

  assign dac1_data     = dac1_q;
  assign dac2_data     = dac2_q;
  assign dac_valid     = dac_valid_q;
  assign streaming     = (state_q == S_RUN);
  assign underflow     = underflow_q;
  assign underflow_cnt = underflow_cnt_q;
  assign fifo_level    = level;
  assign state_dbg     = state_q;

endmodule
